// File: rtl/uart_router.sv
// Routes one host UART to one of N_CH peripheral UARTs, deferring selection changes until both lines idle.
// Optional feature macro UART_ROUTER_TIMEOUT_EN adds a forced switch after TIMEOUT_CYCLES and the timeout_flag port.
module uart_router #(
  parameter int unsigned N_CH           = 3,
  parameter int unsigned SEL_W          = 2,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned IDLE_CYCLES    = 1042,
  parameter int unsigned RST_SEL        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic             host_tx,
  output logic             host_rx,
  input  logic [N_CH-1:0]  periph_tx,
  output logic [N_CH-1:0]  periph_rx,
  output logic [SEL_W-1:0] active_sel,
  output logic             switch_pending,
  output logic             switch_done,
`ifdef UART_ROUTER_TIMEOUT_EN
  output logic             timeout_flag,
`endif
  output logic             sel_err
);

  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [SEL_W-1:0] RST_SEL_V = SEL_W'(RST_SEL);

  typedef enum logic [1:0] {ACTIVE, PENDING, SWITCH} state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  sel_s1, sel_q, target, target_nxt;
  logic              sel_valid;
  logic [SYNC_STAGES-1:0] host_sync;
  logic [N_CH-1:0]   periph_sync [SYNC_STAGES];
  logic              host_s, periph_act_s;
  logic [IDLE_W-1:0] idle_cnt;

  // Synchronisers reset to mark so a reset never produces a spurious start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_sync <= '1;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) periph_sync[i] <= '1;
      sel_s1    <= RST_SEL_V;
      sel_q     <= RST_SEL_V;
    end else begin
      host_sync      <= {host_sync[SYNC_STAGES-2:0], host_tx};
      periph_sync[0] <= periph_tx;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) periph_sync[i] <= periph_sync[i-1];
      sel_s1    <= sel;
      sel_q     <= sel_s1;
    end
  end

  assign host_s    = host_sync[SYNC_STAGES-1];
  assign sel_valid = (32'(sel_q) < N_CH);
  assign sel_err   = !sel_valid;
  assign switch_pending = (state == PENDING);

  always_comb begin
    periph_act_s = 1'b1;
    for (int unsigned i = 0; i < N_CH; i++)
      if (active_sel == SEL_W'(i)) periph_act_s = periph_sync[SYNC_STAGES-1][i];
  end

`ifdef UART_ROUTER_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              retarget, forced, forced_nxt;

  assign retarget = (state == PENDING) && sel_valid && (sel_q != active_sel) && (sel_q != target);
`endif

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
`ifdef UART_ROUTER_TIMEOUT_EN
    forced_nxt = 1'b0;
`endif
    case (state)
      ACTIVE: begin
        if (sel_valid && (sel_q != active_sel)) begin
          target_nxt = sel_q;
          state_nxt  = PENDING;
        end
      end
      PENDING: begin
        // Cancel wins over an idle-triggered switch in the same cycle.
        if (sel_q == active_sel) begin
          state_nxt = ACTIVE;
        end else begin
          if (sel_valid && (sel_q != target)) target_nxt = sel_q;
          if (idle_cnt == IDLE_W'(IDLE_CYCLES)) begin
            state_nxt = SWITCH;
          end
`ifdef UART_ROUTER_TIMEOUT_EN
          else if ((wait_cnt == WAIT_W'(TIMEOUT_CYCLES)) && !retarget) begin
            state_nxt  = SWITCH;
            forced_nxt = 1'b1;
          end
`endif
        end
      end
      SWITCH:  state_nxt = ACTIVE;
      default: state_nxt = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACTIVE;
      target      <= RST_SEL_V;
      active_sel  <= RST_SEL_V;
      switch_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      target      <= target_nxt;
      switch_done <= (state == SWITCH);
      if (state == SWITCH) active_sel <= target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state == SWITCH || !host_s || !periph_act_s) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_W'(IDLE_CYCLES)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Output register; the SWITCH cycle parks every line at mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rx   <= 1'b1;
      periph_rx <= '1;
    end else begin
      host_rx <= (state == SWITCH) ? 1'b1 : periph_act_s;
      for (int unsigned i = 0; i < N_CH; i++)
        periph_rx[i] <= (state != SWITCH && active_sel == SEL_W'(i)) ? host_s : 1'b1;
    end
  end

`ifdef UART_ROUTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      forced       <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      if (state != PENDING || retarget) wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(TIMEOUT_CYCLES)) wait_cnt <= wait_cnt + 1'b1;
      if (state == PENDING) forced <= forced_nxt;
      timeout_flag <= (state == SWITCH) && forced;
    end
  end
`endif

endmodule
